// File: rtl/barrel_unshift_pkg.sv
// barrel_unshift_pkg: shared port-count/width defaults and port-word field layout helpers
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
package barrel_unshift_pkg;
  function automatic int port_w(input int sel_w, input int data_w);
    return 1 + 2 * sel_w + data_w;
  endfunction
  function automatic int dst_lsb(input int data_w);
    return data_w;
  endfunction
  function automatic int vld_bit(input int sel_w, input int data_w);
    return 2 * sel_w + data_w;
  endfunction
endpackage

// File: rtl/barrel_unshift_stage.sv
// barrel_unshift_stage: one registered right-rotate-by-2^BIT stage carrying select and valid along
module barrel_unshift_stage #(
  parameter int PORT_NUM = 4,
  parameter int PORT_W = 13,
  parameter int SEL_W = 2,
  parameter int BIT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hold,
  input  logic                       valid_in,
  input  logic [SEL_W-1:0]           sel_in,
  input  logic [PORT_NUM*PORT_W-1:0] data_in,
  output logic                       valid_out,
  output logic [SEL_W-1:0]           sel_out,
  output logic [PORT_NUM*PORT_W-1:0] data_out
);
  localparam int DIST = 1 << BIT;
  logic [PORT_NUM*PORT_W-1:0] rot;
  for (genvar j = 0; j < PORT_NUM; j++) begin : g_rot
    assign rot[j*PORT_W +: PORT_W] = data_in[((j + DIST) % PORT_NUM)*PORT_W +: PORT_W];
  end
  // Advance the stage unless stalled; reset wins over hold
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      sel_out   <= '0;
      valid_out <= 1'b0;
    end else if (!hold) begin
      data_out  <= sel_in[BIT] ? rot : data_in;
      sel_out   <= sel_in;
      valid_out <= valid_in;
    end
  end
endmodule

// File: rtl/barrel_unshift.sv
// barrel_unshift: pipelined inverse rotator; optional sticky dst checker under BARREL_UNSHIFT_CHECK_EN
module barrel_unshift
  import barrel_unshift_pkg::*;
#(
  parameter int PORT_NUM = `PORT_NUB_TOTAL,
  parameter int DATA_W = `DATA_WIDTH,
  localparam int SEL_W = $clog2(PORT_NUM),
  localparam int PORT_W = port_w(SEL_W, DATA_W)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hold,
  input  logic                       valid_in,
  input  logic [SEL_W-1:0]           select,
  input  logic [PORT_NUM*PORT_W-1:0] port_in,
  output logic                       valid_out,
  output logic [PORT_NUM*PORT_W-1:0] port_out,
  output logic                       err
);
  logic [PORT_NUM*PORT_W-1:0] d [SEL_W+1];
  logic [SEL_W-1:0]           s [SEL_W+1];
  logic                       v [SEL_W+1];
  assign d[0] = port_in;
  assign s[0] = select;
  assign v[0] = valid_in;
  for (genvar i = 0; i < SEL_W; i++) begin : g_stage
    barrel_unshift_stage #(
      .PORT_NUM(PORT_NUM),
      .PORT_W(PORT_W),
      .SEL_W(SEL_W),
      .BIT(i)
    ) u_stage (
      .clk(clk),
      .rst(rst),
      .hold(hold),
      .valid_in(v[i]),
      .sel_in(s[i]),
      .data_in(d[i]),
      .valid_out(v[i+1]),
      .sel_out(s[i+1]),
      .data_out(d[i+1])
    );
  end
  assign port_out  = d[SEL_W];
  assign valid_out = v[SEL_W];
`ifdef BARREL_UNSHIFT_CHECK_EN
  logic [PORT_NUM-1:0] bad;
  logic                hit;
  logic                err_r;
  for (genvar j = 0; j < PORT_NUM; j++) begin : g_chk
    assign bad[j] = port_out[j*PORT_W + vld_bit(SEL_W, DATA_W)] &&
                    port_out[j*PORT_W + dst_lsb(DATA_W) +: SEL_W] != SEL_W'(j);
  end
  assign hit = valid_out && |bad;
  // Latch any misrouted word until reset; err also reflects the offending cycle itself
  always_ff @(posedge clk) begin
    if (rst) err_r <= 1'b0;
    else if (hit) err_r <= 1'b1;
  end
  assign err = err_r | hit;
`else
  assign err = 1'b0;
`endif
endmodule
